// File: rtl/vga_timing_if.sv
// Signal bundle between the VGA timing controller and its neighbours.
// The controller uses the slave view; the divider/pixel path side uses the master view.
interface vga_timing_if;
  logic       pix_en;
  logic       run;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic       busy;

  modport master (
    output pix_en, run,
    input  hsync, vsync, active, x, y, frame_start, busy
  );

  modport slave (
    input  pix_en, run,
    output hsync, vsync, active, x, y, frame_start, busy
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: steps x/y once per pixel enable and decodes sync/active from the new position.
// Scanning starts and stops only on frame boundaries.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic        clk,
  input logic        rst,
  vga_timing_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS       = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS       = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_e;

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       frame_start_q, frame_start_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  // run only matters at the last pixel of a frame (or while idle)
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pix_en && bus.run) begin
          state_d       = RUN;
          x_d           = '0;
          y_d           = '0;
          frame_start_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.pix_en) begin
          if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
              y_d = '0;
              if (bus.run) frame_start_d = 1'b1;
              else         state_d       = IDLE;
            end else begin
              y_d = y_q + 10'd1;
            end
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode from the next position so all outputs describe the same pixel
  always_comb begin
    busy_d   = (state_d == RUN);
    active_d = busy_d && (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d  = !(busy_d && (x_d >= H_SYNC_BEG) && (x_d < H_SYNC_END));
    vsync_d  = !(busy_d && (y_d >= V_SYNC_BEG) && (y_d < V_SYNC_END));
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.active      = active_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;

endmodule
